// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: memory-wait freeze, taken-branch
// flush and load-use bubble in fixed priority, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_memtoreg,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_keep,
    output logic             if_keep,
    output logic             if_flush,
    output logic             id_keep,
    output logic             id_nop,
    output logic             ex_keep,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(BRANCH_PENALTY - 1);

    state_t     state, state_nxt;
    logic [1:0] flush_left, flush_left_nxt;
    logic       resume_flush, resume_flush_nxt;
    logic       lu, freeze, bubble, lu_stall, branch_acc, run_eval, flush_step;

    always_comb begin
        lu = ex_regwrite && (ex_memtoreg == 2'b01) && (ex_wreg != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_wreg)) || (id_use_rs2 && (id_rs2 == ex_wreg)));
        state_nxt        = state;
        flush_left_nxt   = flush_left;
        resume_flush_nxt = resume_flush;
        freeze           = 1'b0;
        bubble           = 1'b0;
        lu_stall         = 1'b0;
        branch_acc       = 1'b0;
        run_eval         = 1'b0;
        flush_step       = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze           = 1'b1;
                    resume_flush_nxt = 1'b0;
                    state_nxt        = MEM_WAIT;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready)
                    freeze = 1'b1;
                else if (resume_flush)
                    flush_step = 1'b1;
                else
                    run_eval = 1'b1;
            end
            FLUSH: begin
                // A memory stall mid-flush parks the remaining bubbles until the access completes.
                if (mem_req && !mem_ready) begin
                    freeze           = 1'b1;
                    resume_flush_nxt = 1'b1;
                    state_nxt        = MEM_WAIT;
                end else begin
                    flush_step = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (run_eval) begin
            state_nxt = RUN;
            if (ex_branch_taken) begin
                bubble     = 1'b1;
                branch_acc = 1'b1;
                if (BRANCH_PENALTY > 1) begin
                    flush_left_nxt = FLUSH_INIT;
                    state_nxt      = FLUSH;
                end
            end else if (lu) begin
                lu_stall = 1'b1;
            end
        end

        if (flush_step) begin
            bubble         = 1'b1;
            flush_left_nxt = flush_left - 2'd1;
            state_nxt      = (flush_left <= 2'd1) ? RUN : FLUSH;
        end
    end

    assign pc_keep  = rst && (freeze || lu_stall);
    assign if_keep  = rst && (freeze || lu_stall);
    assign if_flush = rst && bubble;
    assign id_keep  = rst && freeze;
    assign id_nop   = rst && (bubble || lu_stall);
    assign ex_keep  = rst && freeze;
    assign busy     = rst && (state != RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            flush_left   <= 2'd0;
            resume_flush <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            flush_left   <= flush_left_nxt;
            resume_flush <= resume_flush_nxt;
            if (pc_keep && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_acc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two builds (penalty 2 / 4-bit counters, penalty 3 / 8-bit counters)
// driven in lockstep and compared each cycle against a bubble-debt reference model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_wreg;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_branch_taken, mem_req, mem_ready;
    logic [1:0] ex_memtoreg;

    logic       pc_keep_a, if_keep_a, if_flush_a, id_keep_a, id_nop_a, ex_keep_a, busy_a;
    logic [3:0] stall_cnt_a, flush_cnt_a;
    logic       pc_keep_b, if_keep_b, if_flush_b, id_keep_b, id_nop_b, ex_keep_b, busy_b;
    logic [7:0] stall_cnt_b, flush_cnt_b;

    pipe_hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_keep(pc_keep_a), .if_keep(if_keep_a),
        .if_flush(if_flush_a), .id_keep(id_keep_a), .id_nop(id_nop_a), .ex_keep(ex_keep_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .busy(busy_a)
    );

    pipe_hazard_ctrl #(.BRANCH_PENALTY(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_keep(pc_keep_b), .if_keep(if_keep_b),
        .if_flush(if_flush_b), .id_keep(id_keep_b), .id_nop(id_nop_b), .ex_keep(ex_keep_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .busy(busy_b)
    );

    // Reference model: "owed" is how many wrong-path bubbles are still due, "waiting" means a
    // memory access is outstanding; counters saturate at cmax.
    typedef struct {
        int owed;
        bit waiting;
        int stall;
        int flush;
    } mdl_t;

    mdl_t ma, mb, na, nb;
    logic [6:0] exp_a, exp_b;
    int checks = 0;
    int errors = 0;
    bit cnt_valid = 1'b0;

    task automatic modelStep(input mdl_t m, input int bp, input int cmax,
                             output logic [6:0] exp_out, output mdl_t n);
        bit frz, bub, lus, acc, decide, hazard, stall_req;
        n = m;
        frz = 0; bub = 0; lus = 0; acc = 0; decide = 0;
        hazard = ex_regwrite && ex_memtoreg == 2'b01 && ex_wreg != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_wreg) || (id_use_rs2 && id_rs2 == ex_wreg));
        stall_req = mem_req && !mem_ready;
        if (!rst) begin
            exp_out = 7'b0;
            n = '{0, 1'b0, 0, 0};
        end else begin
            if (m.waiting) begin
                if (!mem_ready) frz = 1;
                else begin
                    n.waiting = 0;
                    if (m.owed > 0) begin bub = 1; n.owed = m.owed - 1; end
                    else decide = 1;
                end
            end else if (m.owed > 0) begin
                if (stall_req) begin frz = 1; n.waiting = 1; end
                else begin bub = 1; n.owed = m.owed - 1; end
            end else if (stall_req) begin
                frz = 1; n.waiting = 1;
            end else begin
                decide = 1;
            end
            if (decide) begin
                if (ex_branch_taken) begin bub = 1; acc = 1; n.owed = bp - 1; end
                else if (hazard) lus = 1;
            end
            if ((frz || lus) && m.stall < cmax) n.stall = m.stall + 1;
            if (acc && m.flush < cmax) n.flush = m.flush + 1;
            exp_out = {frz | lus, frz | lus, bub, frz, bub | lus, frz, m.waiting || (m.owed > 0)};
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic r, input int rs1, input logic u1, input int rs2,
                                 input logic u2, input int wreg, input logic rw,
                                 input logic [1:0] m2r, input logic br,
                                 input logic mreq, input logic mrdy);
        rst = r;
        id_rs1 = 5'(rs1); id_use_rs1 = u1;
        id_rs2 = 5'(rs2); id_use_rs2 = u2;
        ex_wreg = 5'(wreg); ex_regwrite = rw; ex_memtoreg = m2r;
        ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        #1;
        modelStep(ma, 2, 15, exp_a, na);
        modelStep(mb, 3, 255, exp_b, nb);
        checkOutput("ctrl_a", 32'({pc_keep_a, if_keep_a, if_flush_a, id_keep_a, id_nop_a, ex_keep_a, busy_a}), 32'(exp_a));
        checkOutput("ctrl_b", 32'({pc_keep_b, if_keep_b, if_flush_b, id_keep_b, id_nop_b, ex_keep_b, busy_b}), 32'(exp_b));
        if (cnt_valid) begin
            checkOutput("stall_a", 32'(stall_cnt_a), 32'(ma.stall));
            checkOutput("flush_a", 32'(flush_cnt_a), 32'(ma.flush));
            checkOutput("stall_b", 32'(stall_cnt_b), 32'(mb.stall));
            checkOutput("flush_b", 32'(flush_cnt_b), 32'(mb.flush));
        end
        @(posedge clk);
        ma = na;
        mb = nb;
        if (!r) cnt_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        ma = '{0, 1'b0, 0, 0};
        mb = '{0, 1'b0, 0, 0};
        @(negedge clk);
        doReset();
        doReset();
        idle(1);

        $display("[TB] load-use");
        applyStimulus(1, 5, 1, 1, 1, 5, 1, 2'b01, 0, 0, 0);
        idle(1);
        checkOutput("lu_stall_const", 32'(stall_cnt_a), 32'd1);

        $display("[TB] no false load-use");
        applyStimulus(1, 0, 1, 0, 1, 0, 1, 2'b01, 0, 0, 0);
        applyStimulus(1, 7, 1, 3, 0, 7, 1, 2'b00, 0, 0, 0);
        applyStimulus(1, 3, 0, 9, 1, 9, 0, 2'b01, 0, 0, 0);
        applyStimulus(1, 4, 0, 9, 1, 9, 1, 2'b01, 0, 0, 0);

        $display("[TB] branch flush");
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        idle(4);
        checkOutput("br_flush_const", 32'(flush_cnt_a), 32'd1);

        $display("[TB] simultaneous events");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 5, 1, 0, 0, 5, 1, 2'b01, 1, 1, 0);
        applyStimulus(1, 5, 1, 0, 0, 5, 1, 2'b01, 1, 1, 1);
        idle(4);
        checkOutput("sim_stall_const", 32'(stall_cnt_a), 32'd3);

        $display("[TB] freeze inside flush");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        idle(4);

        $display("[TB] reset mid-flush");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        doReset();
        idle(2);
        checkOutput("rst_busy_const", 32'(busy_b), 32'd0);

        $display("[TB] saturation");
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        idle(1);
        checkOutput("sat_a_const", 32'(stall_cnt_a), 32'd15);
        checkOutput("sat_b_const", 32'(stall_cnt_b), 32'd20);

        $display("[TB] random");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 39) != 0,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the IF/ID/EX/MEM registers and generates the freeze and bubble signals for them. Its `id_keep`/`id_nop` outputs connect directly to the `keep`/`nop` inputs of the decode stage. It resolves three hazard classes with fixed priority: data-memory wait, then taken branch/jump flush, then load-use. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- `BRANCH_PENALTY`, default 1: number of cycles the wrong-path flush lasts after a taken branch or jump is resolved in EX (legal values 1–3).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; every register updates on the posedge.
- `rst`  in  1  synchronous, active-low reset; sampled on the posedge of `clk`.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction currently in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads rs1 / rs2.
- `ex_wreg`  in  5  destination register of the instruction in EX.
- `ex_regwrite`  in  1  the EX instruction writes a register.
- `ex_memtoreg`  in  2  writeback select of the EX instruction; `2'b01` marks a load.
- `ex_branch_taken`  in  1  the branch/jal/jalr in EX redirects the PC this cycle.
- `mem_req`  in  1  MEM stage has an active data-memory access.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_keep`  out  1  hold PC.
- `if_keep`  out  1  hold the IF/ID register.
- `if_flush`  out  1  load an `addi x0,x0,0` bubble into IF/ID.
- `id_keep`  out  1  hold the ID/EX register (decode `keep`).
- `id_nop`  out  1  load a bubble into ID/EX (decode `nop`).
- `ex_keep`  out  1  hold the EX/MEM register.
- `stall_cnt`  out  `CNT_W`  cycles in which `pc_keep` = 1.
- `flush_cnt`  out  `CNT_W`  accepted taken-branch events.
- `busy`  out  1  FSM is not in RUN.

## Operation
- FSM states: RUN, MEM_WAIT, FLUSH. A `flush_left` counter (2 bits) runs alongside.
- Outputs are combinational from state and current inputs. The state and counters are registered.
- **Load-use condition (`lu`):** `ex_regwrite` & `ex_memtoreg == 2'b01` & `ex_wreg != 0` & ((`id_use_rs1` & `id_rs1 == ex_wreg`) | (`id_use_rs2` & `id_rs2 == ex_wreg`)).

RUN, evaluated in priority order:
1. `mem_req & !mem_ready`: assert `pc_keep`, `if_keep`, `id_keep`, `ex_keep`. Next state MEM_WAIT.
2. `ex_branch_taken`: assert `if_flush` and `id_nop`. Increment `flush_cnt`. If `BRANCH_PENALTY > 1`, load `flush_left = BRANCH_PENALTY-1` and go to FLUSH; otherwise stay in RUN.
3. `lu`: assert `pc_keep`, `if_keep`, `id_nop` for this cycle only. Stay in RUN. The bubble clears the hazard on the next cycle.
4. Otherwise all control outputs are 0.

MEM_WAIT:
- While `!mem_ready`, hold the same four keeps. `ex_branch_taken` and `lu` are ignored.
- In the cycle `mem_ready` = 1, outputs are computed exactly as in RUN steps 2–4, but step 1 does not apply. The next state is taken from that evaluation.

FLUSH:
- Assert `if_flush` and `id_nop`, and decrement `flush_left`. Go to RUN when `flush_left` reaches 1.
- `mem_req & !mem_ready` in FLUSH has priority: freeze as in MEM_WAIT and keep `flush_left`. After the freeze the FSM returns to FLUSH. MEM_WAIT latches a `resume_flush` bit to do this.
- A new `ex_branch_taken` in FLUSH is ignored, because EX holds a bubble.

Invariants:
- `id_keep` and `id_nop` are never both 1.
- `if_keep` and `if_flush` are never both 1.

Counters:
- `stall_cnt` increments every cycle `pc_keep` = 1.
- `flush_cnt` increments once per accepted branch event.
- Both saturate at all-ones and never wrap.

## Timing
- Control outputs have zero-cycle latency: they are valid in the same cycle as the triggering inputs, before the posedge that samples them.
- Load-use costs exactly 1 bubble.
- A taken branch costs `BRANCH_PENALTY` bubbles, not counting memory-wait cycles.
- Reset (`rst` = 0 at a posedge):
  - state = RUN, `flush_left` = 0, `resume_flush` = 0, `stall_cnt` = 0, `flush_cnt` = 0.
  - During the reset cycle all control outputs are forced to 0 and `busy` = 0.
- Reset mid-MEM_WAIT or mid-FLUSH aborts the operation. The first cycle after reset is in RUN.

## Test plan
- **Load-use:** `lw x5` in EX, `add x6,x5,x1` in ID (`id_use_rs1` = 1). Expect 1 cycle with `pc_keep` = `if_keep` = `id_nop` = 1 and `id_keep` = 0, then outputs 0. `stall_cnt` = 1.
- **No false load-use:** `ex_wreg` = 0, or `ex_memtoreg` = `2'b00`, with a matching rs1. Expect no stall.
- **Branch flush:** `ex_branch_taken` pulse with `BRANCH_PENALTY` = 2. Expect `if_flush` = `id_nop` = 1 for 2 consecutive cycles, `flush_cnt` = 1, then back to RUN.
- **Simultaneous events:** `mem_req` = 1 with `mem_ready` = 0 for 3 cycles, while `ex_branch_taken` = 1 and `lu` = 1. Expect 3 cycles of all keeps. On the `mem_ready` cycle, expect the flush (branch outranks load-use) and no `pc_keep`. `stall_cnt` = 3.
- **Reset mid-flush:** assert `rst` = 0 inside FLUSH. Next cycle all outputs are 0, counters are 0, `busy` = 0.
- **Saturation:** preload `stall_cnt` near max via a `CNT_W` = 4 build. Force 20 stall cycles. Expect `stall_cnt` to hold at 15.
